gate_sensor_decoder: RTL and testbench



---
 rtl/gate_sensor_pkg.sv | 18 +
 rtl/sensor_debouncer.sv | 44 ++++
 rtl/gate_sensor_decoder.sv | 141 ++++++++++++++
 tb/tb_gate_sensor_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_sensor_pkg.sv
// rtl/gate_sensor_pkg.sv - shared state encoding and defaults for the gate sensor decoder
package gate_sensor_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENT_A      = 3'd1,
        ST_ENT_AB     = 3'd2,
        ST_ENT_B      = 3'd3,
        ST_EXT_B      = 3'd4,
        ST_EXT_BA     = 3'd5,
        ST_EXT_A      = 3'd6,
        ST_WAIT_CLEAR = 3'd7
    } gate_state_t;

endpackage

// File: rtl/sensor_debouncer.sv
// rtl/sensor_debouncer.sv - two-flop synchroniser plus stability-count debouncer for one beam
module sensor_debouncer
    import gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The Nth consecutive disagreeing cycle commits the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/gate_sensor_decoder.sv
// rtl/gate_sensor_decoder.sv - beam-pair direction decoder; GATE_SENSOR_TIMEOUT_EN adds dwell abort
module gate_sensor_decoder
    import gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_a_raw,
    input  logic sensor_b_raw,
    output logic entry_detected,
    output logic exit_detected,
    output logic gate_busy,
    output logic fault
);

    logic        w_a;
    logic        w_b;
    logic        w_timeout;
    logic        w_entry;
    logic        w_exit;
    logic        w_fault;
    gate_state_t w_next;

    gate_state_t r_state;
    logic        r_entry;
    logic        r_exit;
    logic        r_busy;
    logic        r_fault;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (sensor_a_raw),
        .o_level (w_a)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (sensor_b_raw),
        .o_level (w_b)
    );

`ifdef GATE_SENSOR_TIMEOUT_EN
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] DWELL_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_dwell;

    assign w_timeout = (r_state != ST_IDLE) && (r_state != ST_WAIT_CLEAR) && (r_dwell == DWELL_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if ((w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_WAIT_CLEAR)) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_a && !w_b)       w_next = ST_ENT_A;
                else if (!w_a && w_b)  w_next = ST_EXT_B;
                else if (w_a && w_b)   w_next = ST_WAIT_CLEAR;
            end
            ST_ENT_A: begin
                if (w_a && w_b)        w_next = ST_ENT_AB;
                else if (!w_a && w_b)  w_next = ST_ENT_B;
                else if (!w_a && !w_b) w_next = ST_IDLE;
            end
            ST_ENT_AB: begin
                if (!w_a && w_b)       w_next = ST_ENT_B;
                else if (w_a && !w_b)  w_next = ST_ENT_A;
                else if (!w_a && !w_b) w_next = ST_IDLE;
            end
            ST_ENT_B: begin
                if (!w_a && !w_b)      w_next = ST_IDLE;
                else if (w_a && w_b)   w_next = ST_ENT_AB;
                else if (w_a && !w_b)  w_next = ST_ENT_A;
            end
            ST_EXT_B: begin
                if (w_a && w_b)        w_next = ST_EXT_BA;
                else if (w_a && !w_b)  w_next = ST_EXT_A;
                else if (!w_a && !w_b) w_next = ST_IDLE;
            end
            ST_EXT_BA: begin
                if (w_a && !w_b)       w_next = ST_EXT_A;
                else if (!w_a && w_b)  w_next = ST_EXT_B;
                else if (!w_a && !w_b) w_next = ST_IDLE;
            end
            ST_EXT_A: begin
                if (!w_a && !w_b)      w_next = ST_IDLE;
                else if (w_a && w_b)   w_next = ST_EXT_BA;
                else if (!w_a && w_b)  w_next = ST_EXT_B;
            end
            ST_WAIT_CLEAR: begin
                if (!w_a && !w_b)      w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next = ST_WAIT_CLEAR;
        end
    end

    // A timed-out crossing never counts, even if the beams clear on the same cycle.
    assign w_entry = (r_state == ST_ENT_B) && !w_a && !w_b && !w_timeout;
    assign w_exit  = (r_state == ST_EXT_A) && !w_a && !w_b && !w_timeout;
    assign w_fault = ((r_state == ST_IDLE) && w_a && w_b) || w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_entry <= 1'b0;
            r_exit  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_entry;
            r_exit  <= w_exit;
            r_busy  <= (w_next != ST_IDLE);
            r_fault <= w_fault;
        end
    end

    assign entry_detected = r_entry;
    assign exit_detected  = r_exit;
    assign gate_busy      = r_busy;
    assign fault          = r_fault;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb/tb_gate_sensor_decoder.sv - directed self-checking bench for gate_sensor_decoder
`timescale 1ns/1ps
module tb_gate_sensor_decoder;

    logic clk = 1'b0;
    logic reset_n;
    logic sensor_a_raw;
    logic sensor_b_raw;
    logic entry_detected;
    logic exit_detected;
    logic gate_busy;
    logic fault;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc       = 0;
    int entry_cnt = 0;
    int exit_cnt  = 0;
    int fault_cnt = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    int entry_cyc = -1;
    int exit_cyc  = -1;
    int fault_cyc = -1;

    gate_sensor_decoder #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_a_raw   (sensor_a_raw),
        .sensor_b_raw   (sensor_b_raw),
        .entry_detected (entry_detected),
        .exit_detected  (exit_detected),
        .gate_busy      (gate_busy),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (entry_detected === 1'b1) begin
            entry_cnt <= entry_cnt + 1;
            entry_cyc <= cyc;
        end
        if (exit_detected === 1'b1) begin
            exit_cnt <= exit_cnt + 1;
            exit_cyc <= cyc;
        end
        if (fault === 1'b1) begin
            fault_cnt <= fault_cnt + 1;
            fault_cyc <= cyc;
        end
        if (entry_detected === 1'b1 && exit_detected === 1'b1) both_cnt <= both_cnt + 1;
        if (gate_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        sensor_a_raw = 1'b0;
        sensor_b_raw = 1'b0;
        idle(3);
        n_tests++; if (entry_detected !== 1'b0) begin n_fail++; $display("FAIL reset_entry got=%b exp=0", entry_detected); end
        n_tests++; if (exit_detected !== 1'b0) begin n_fail++; $display("FAIL reset_exit got=%b exp=0", exit_detected); end
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", gate_busy); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
        reset_n = 1'b1;
        idle(5);
    endtask

    task automatic test_entry;
        int e0, x0, f0, rel;
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt;
        sensor_a_raw = 1'b1; idle(20);
        n_tests++; if (gate_busy !== 1'b1) begin n_fail++; $display("FAIL entry_busy got=%b exp=1", gate_busy); end
        sensor_b_raw = 1'b1; idle(20);
        sensor_a_raw = 1'b0; idle(20);
        rel = cyc;
        sensor_b_raw = 1'b0; idle(15);
        n_tests++; if (entry_cnt - e0 != 1) begin n_fail++; $display("FAIL entry_count got=%0d exp=1", entry_cnt - e0); end
        n_tests++; if (entry_cyc != rel + 7) begin n_fail++; $display("FAIL entry_latency got=%0d exp=%0d", entry_cyc, rel + 7); end
        n_tests++; if (exit_cnt - x0 != 0 || fault_cnt - f0 != 0) begin n_fail++; $display("FAIL entry_side got exit=%0d fault=%0d exp=0,0", exit_cnt - x0, fault_cnt - f0); end
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL entry_busy_after got=%b exp=0", gate_busy); end
    endtask

    task automatic test_exit;
        int e0, x0, rel;
        e0 = entry_cnt; x0 = exit_cnt;
        sensor_b_raw = 1'b1; idle(20);
        sensor_a_raw = 1'b1; idle(20);
        sensor_b_raw = 1'b0; idle(20);
        rel = cyc;
        sensor_a_raw = 1'b0; idle(15);
        n_tests++; if (exit_cnt - x0 != 1) begin n_fail++; $display("FAIL exit_count got=%0d exp=1", exit_cnt - x0); end
        n_tests++; if (exit_cyc != rel + 7) begin n_fail++; $display("FAIL exit_latency got=%0d exp=%0d", exit_cyc, rel + 7); end
        n_tests++; if (entry_cnt - e0 != 0) begin n_fail++; $display("FAIL exit_no_entry got=%0d exp=0", entry_cnt - e0); end
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL exit_busy_after got=%b exp=0", gate_busy); end
    endtask

    task automatic test_glitch;
        int e0, x0, f0, b0;
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt; b0 = busy_cnt;
        for (int i = 0; i < 10; i++) begin
            sensor_a_raw = 1'b1; idle(3);
            sensor_a_raw = 1'b0; idle(6);
        end
        idle(10);
        n_tests++; if (busy_cnt - b0 != 0) begin n_fail++; $display("FAIL glitch_busy got=%0d cycles exp=0", busy_cnt - b0); end
        n_tests++; if (entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0 != 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp=0", entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0); end
    endtask

    task automatic test_backout;
        int e0, x0, f0;
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt;
        sensor_a_raw = 1'b1; idle(20);
        sensor_b_raw = 1'b1; idle(20);
        sensor_b_raw = 1'b0; idle(20);
        n_tests++; if (gate_busy !== 1'b1) begin n_fail++; $display("FAIL backout_busy_mid got=%b exp=1", gate_busy); end
        sensor_a_raw = 1'b0; idle(15);
        n_tests++; if (entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0 != 0) begin n_fail++; $display("FAIL backout_pulses got=%0d exp=0", entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0); end
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL backout_busy_after got=%b exp=0", gate_busy); end
    endtask

    task automatic test_simultaneous;
        int e0, x0, f0, rel;
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt;
        rel = cyc;
        sensor_a_raw = 1'b1; sensor_b_raw = 1'b1; idle(20);
        n_tests++; if (fault_cnt - f0 != 1) begin n_fail++; $display("FAIL simul_fault_count got=%0d exp=1", fault_cnt - f0); end
        n_tests++; if (fault_cyc != rel + 7) begin n_fail++; $display("FAIL simul_fault_latency got=%0d exp=%0d", fault_cyc, rel + 7); end
        n_tests++; if (gate_busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_hold got=%b exp=1", gate_busy); end
        sensor_b_raw = 1'b0; idle(15);
        n_tests++; if (gate_busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_one_clear got=%b exp=1", gate_busy); end
        sensor_a_raw = 1'b0; idle(15);
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy_after got=%b exp=0", gate_busy); end
        n_tests++; if (entry_cnt - e0 + exit_cnt - x0 != 0) begin n_fail++; $display("FAIL simul_count_pulses got=%0d exp=0", entry_cnt - e0 + exit_cnt - x0); end
    endtask

    task automatic test_back_to_back;
        int e0, rel;
        e0 = entry_cnt;
        for (int i = 0; i < 2; i++) begin
            sensor_a_raw = 1'b1; idle(10);
            sensor_b_raw = 1'b1; idle(10);
            sensor_a_raw = 1'b0; idle(10);
            rel = cyc;
            sensor_b_raw = 1'b0; idle(8);
        end
        idle(10);
        n_tests++; if (entry_cnt - e0 != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", entry_cnt - e0); end
        n_tests++; if (entry_cyc != rel + 7) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", entry_cyc, rel + 7); end
    endtask

    task automatic test_long_hold;
        int e0, x0, f0, rel;
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt;
        rel = cyc;
        sensor_a_raw = 1'b1; idle(200);
`ifdef GATE_SENSOR_TIMEOUT_EN
        n_tests++; if (fault_cnt - f0 != 1) begin n_fail++; $display("FAIL timeout_fault_count got=%0d exp=1", fault_cnt - f0); end
        n_tests++; if (fault_cyc != rel + 57) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", fault_cyc, rel + 57); end
`else
        n_tests++; if (fault_cnt - f0 != 0) begin n_fail++; $display("FAIL hold_no_fault got=%0d exp=0", fault_cnt - f0); end
`endif
        n_tests++; if (gate_busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy got=%b exp=1", gate_busy); end
        sensor_a_raw = 1'b0; idle(15);
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy_after got=%b exp=0", gate_busy); end
        n_tests++; if (entry_cnt - e0 + exit_cnt - x0 != 0) begin n_fail++; $display("FAIL hold_count_pulses got=%0d exp=0", entry_cnt - e0 + exit_cnt - x0); end
    endtask

    task automatic test_reset_mid;
        int e0, x0, f0;
        sensor_a_raw = 1'b1; idle(20);
        sensor_b_raw = 1'b1; idle(20);
        reset_n = 1'b0;
        idle(1);
        n_tests++; if ({entry_detected, exit_detected, gate_busy, fault} !== 4'b0000) begin n_fail++; $display("FAIL midreset_outputs got=%b exp=0000", {entry_detected, exit_detected, gate_busy, fault}); end
        sensor_a_raw = 1'b0; sensor_b_raw = 1'b0; idle(3);
        e0 = entry_cnt; x0 = exit_cnt; f0 = fault_cnt;
        reset_n = 1'b1; idle(20);
        n_tests++; if (entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0 != 0) begin n_fail++; $display("FAIL midreset_pulses got=%0d exp=0", entry_cnt - e0 + exit_cnt - x0 + fault_cnt - f0); end
        n_tests++; if (gate_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", gate_busy); end
    endtask

    initial begin
        test_reset;
        test_entry;
        test_exit;
        test_glitch;
        test_backout;
        test_simultaneous;
        test_back_to_back;
        test_long_hold;
        test_reset_mid;
        n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL entry_exit_overlap got=%0d exp=0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
